// File: rtl/accum_beat_packer.sv
`timescale 1ns/1ps
// accum_beat_packer
//   Read-out stage for the word-count accumulator array. On kick, reads a
//   contiguous range of DATA_WIDTH-bit counters from the accumulator's
//   synchronous read port and packs LANES counters per BEAT_WIDTH-bit beat.
//   Beats leave on an AXI4-Stream master with full tready backpressure.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   kick           start pulse, honoured only in IDLE
//   busy           high in FETCH and DRAIN
//   done           one-cycle completion pulse
//   offset, words  first accumulator index / entry count, latched on kick
//   beats          ceil(words/LANES), held until the next kick
//   mem_rd_addr    accumulator read address (zero-extended, wraps mod 2^ADDR_WIDTH)
//   mem_rd_q       read data, valid one cycle after the address
//   m_axis_*       AXI4-Stream master (tvalid/tready/tdata/tlast)
module accum_beat_packer #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 64,
    parameter int BEAT_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  kick,
    output logic                  busy,
    output logic                  done,
    input  logic [31:0]           offset,
    input  logic [31:0]           words,
    output logic [31:0]           beats,
    output logic [31:0]           mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_q,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [BEAT_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast
);

    localparam int LANES  = BEAT_WIDTH / DATA_WIDTH;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [31:0]           words_q;
    logic [31:0]           idx_q;      // index of the word whose address is on mem_rd_addr
    logic [31:0]           beats_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    // Read in flight: data for it is on mem_rd_q this cycle.
    logic                  rd_pend_q;
    logic [LANE_W-1:0]     rd_lane_q;
    logic                  rd_buf_q;
    logic                  rd_last_q;

    // Ping-pong beat buffers; out_sel_q points at the one being presented.
    logic [BEAT_WIDTH-1:0] bank_q [2];
    logic [1:0]            full_q;
    logic [1:0]            last_q;
    logic                  out_sel_q;

    logic                  hs;
    logic                  tgt;
    logic                  issue;
    logic                  last_issue;
    logic [32:0]           beats_wide;
    logic [31:0]           beats_calc;
    logic                  unused_offset_hi;

    assign unused_offset_hi = ^offset[31:ADDR_WIDTH];

    assign m_axis_tvalid = full_q[out_sel_q];
    assign m_axis_tlast  = full_q[out_sel_q] & last_q[out_sel_q];
    assign m_axis_tdata  = bank_q[out_sel_q];
    assign mem_rd_addr   = 32'(addr_q);
    assign beats         = beats_q;

    always_comb begin
        beats_wide = {1'b0, words} + 33'd7;
        beats_calc = 32'(beats_wide[32:LANE_W]);
    end

    // A read may be issued when the buffer its data lands in is free, or is
    // handed off downstream on this same edge (it is cleared before the data
    // arrives one cycle later).
    always_comb begin
        hs         = m_axis_tvalid & m_axis_tready;
        tgt        = idx_q[LANE_W];
        issue      = (state_q == S_FETCH) && (!full_q[tgt] || (hs && (out_sel_q == tgt)));
        last_issue = issue && (idx_q == words_q - 32'd1);
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (kick) state_d = (words == 32'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                busy = 1'b1;
                if (last_issue) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                // tlast is only ever set on the final beat, so its handshake
                // marks the end of the transfer.
                if (hs && m_axis_tlast) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            words_q   <= '0;
            idx_q     <= '0;
            beats_q   <= '0;
            addr_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_lane_q <= '0;
            rd_buf_q  <= 1'b0;
            rd_last_q <= 1'b0;
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= '0;
            last_q    <= '0;
            out_sel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && kick) begin
                words_q   <= words;
                idx_q     <= '0;
                beats_q   <= beats_calc;
                addr_q    <= offset[ADDR_WIDTH-1:0];
                rd_pend_q <= 1'b0;
                bank_q[0] <= '0;
                bank_q[1] <= '0;
                full_q    <= '0;
                last_q    <= '0;
                out_sel_q <= 1'b0;
            end else begin
                rd_pend_q <= issue;
                if (issue) begin
                    rd_lane_q <= idx_q[LANE_W-1:0];
                    rd_buf_q  <= tgt;
                    rd_last_q <= last_issue;
                    idx_q     <= idx_q + 32'd1;
                    addr_q    <= addr_q + ADDR_WIDTH'(1);
                end

                // Handed-off buffer is zeroed so a partial final beat has
                // clear upper lanes.
                if (hs) begin
                    full_q[out_sel_q] <= 1'b0;
                    last_q[out_sel_q] <= 1'b0;
                    bank_q[out_sel_q] <= '0;
                    out_sel_q         <= ~out_sel_q;
                end

                if (rd_pend_q) begin
                    for (int unsigned l = 0; l < LANES; l++) begin
                        if (rd_lane_q == LANE_W'(l))
                            bank_q[rd_buf_q][l*DATA_WIDTH +: DATA_WIDTH] <= mem_rd_q;
                    end
                    if (rd_lane_q == LANE_W'(LANES - 1) || rd_last_q) begin
                        full_q[rd_buf_q] <= 1'b1;
                        last_q[rd_buf_q] <= rd_last_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_accum_beat_packer.sv
`timescale 1ns/1ps
// Directed bench for accum_beat_packer with a beat scoreboard.
module tb_accum_beat_packer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         kick = 1'b0;
    logic [31:0]  offset = '0;
    logic [31:0]  words = '0;
    logic         busy, done;
    logic [31:0]  beats, mem_rd_addr;
    logic [63:0]  mem_rd_q = '0;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b1;
    logic [511:0] m_axis_tdata;
    logic         m_axis_tlast;

    accum_beat_packer #(.ADDR_WIDTH(14), .DATA_WIDTH(64), .BEAT_WIDTH(512)) dut (
        .clk(clk), .reset(reset), .kick(kick), .busy(busy), .done(done),
        .offset(offset), .words(words), .beats(beats), .mem_rd_addr(mem_rd_addr),
        .mem_rd_q(mem_rd_q), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    // Accumulator model: Mem[i] = i + 1, one-cycle synchronous read.
    always @(posedge clk) mem_rd_q <= 64'(mem_rd_addr) + 64'd1;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    int           tests = 0;
    int           fails = 0;
    int           hs_count = 0;
    logic         stall_prev = 1'b0;
    logic [511:0] hold_data;
    logic         hold_last;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every handshake and checks
    // tdata/tlast hold while stalled.
    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev) begin
                chk("stall_valid", m_axis_tvalid, 1'b1);
                chk("stall_data", m_axis_tdata, hold_data);
                chk("stall_last", m_axis_tlast, hold_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", m_axis_tdata, e.data);
                    chk("beat_last", m_axis_tlast, e.last);
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            hold_data  = m_axis_tdata;
            hold_last  = m_axis_tlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic expect_xfer(input logic [31:0] off, input logic [31:0] n);
        int nb;
        nb = int'((64'(n) + 64'd7) >> 3);
        for (int b = 0; b < nb; b++) begin
            beat_t e;
            e.data = '0;
            for (int l = 0; l < 8; l++) begin
                longint unsigned k;
                k = longint'(b) * 8 + longint'(l);
                if (k < 64'(n)) e.data[l*64 +: 64] = ((64'(off) + k) % 64'd16384) + 64'd1;
            end
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    // Returns at the start of cycle 1 (kick sampled at the end of cycle 0).
    task automatic do_kick(input logic [31:0] off, input logic [31:0] n);
        offset = off;
        words  = n;
        expect_xfer(off, n);
        kick = 1'b1;
        @(posedge clk); #1;
        kick = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, done, 1'b1);
        @(posedge clk); #1;
        chk({tag, "_once"}, done, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_tvalid"}, m_axis_tvalid, 1'b0);
        chk({tag, "_tlast"}, m_axis_tlast, 1'b0);
        chk({tag, "_tdata"}, m_axis_tdata, '0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_addr"}, mem_rd_addr, 32'd0);
        chk({tag, "_beats"}, beats, 32'd0);
    endtask

    initial begin
        int hs0;
        int n;

        // Reset state
        #2 reset = 1'b0;
        #1 check_zero_outputs("rst");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check_zero_outputs("post_rst");

        // 1: offset 0, 16 words, first tvalid at cycle 10
        m_axis_tready = 1'b1;
        hs0 = hs_count;
        do_kick(32'd0, 32'd16);
        chk("t1_first_addr", mem_rd_addr, 32'd0);
        chk("t1_beats", beats, 32'd2);
        chk("t1_busy", busy, 1'b1);
        repeat (8) @(posedge clk);
        #1 chk("t1_tvalid_c9", m_axis_tvalid, 1'b0);
        @(posedge clk); #1;
        chk("t1_tvalid_c10", m_axis_tvalid, 1'b1);
        wait_done("t1_done", 40);
        chk("t1_beat_count", 32'(hs_count - hs0), 32'd2);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // 2: partial single beat
        hs0 = hs_count;
        do_kick(32'd5, 32'd3);
        chk("t2_beats", beats, 32'd1);
        wait_done("t2_done", 30);
        chk("t2_beat_count", 32'(hs_count - hs0), 32'd1);

        // 3: zero words
        hs0 = hs_count;
        do_kick(32'd0, 32'd0);
        chk("t3_done", done, 1'b1);
        chk("t3_busy", busy, 1'b0);
        chk("t3_tvalid", m_axis_tvalid, 1'b0);
        chk("t3_beats", beats, 32'd0);
        @(posedge clk); #1;
        chk("t3_done_once", done, 1'b0);
        chk("t3_busy_after", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("t3_no_beats", 32'(hs_count - hs0), 32'd0);

        // 4: backpressure, 32 words
        hs0 = hs_count;
        m_axis_tready = 1'b0;
        do_kick(32'd0, 32'd32);
        repeat (40) @(posedge clk);
        #1 chk("t4_addr_held", mem_rd_addr, 32'd16);
        chk("t4_tvalid_stalled", m_axis_tvalid, 1'b1);
        chk("t4_no_xfer_yet", 32'(hs_count - hs0), 32'd0);
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            m_axis_tready = ~m_axis_tready;
            @(posedge clk); #1;
            n++;
        end
        chk("t4_done", done, 1'b1);
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        chk("t4_beat_count", 32'(hs_count - hs0), 32'd4);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);

        // 5: address wrap
        do_kick(32'd16380, 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t5_addr", mem_rd_addr, 32'((16380 + i) % 16384));
            @(posedge clk); #1;
        end
        wait_done("t5_done", 30);

        // 6: reset during the second beat of a 24-word transfer
        hs0 = hs_count;
        do_kick(32'd0, 32'd24);
        n = 0;
        while (hs_count - hs0 < 1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t6_first_beat", 32'(hs_count - hs0), 32'd1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1 check_zero_outputs("t6_abort");
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        hs0 = hs_count;
        repeat (12) @(posedge clk);
        #1 chk("t6_idle_tvalid", m_axis_tvalid, 1'b0);
        chk("t6_idle_busy", busy, 1'b0);
        chk("t6_no_beats", 32'(hs_count - hs0), 32'd0);
        do_kick(32'd0, 32'd8);
        wait_done("t6_restart_done", 30);
        chk("t6_restart_beats", 32'(hs_count - hs0), 32'd1);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
